// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue line-fetch sequencer.
package ifq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT,
        REDIRECT
    } fetch_state_e;

    localparam int LINE_BYTES = 16;
    localparam int LINE_W     = 128;

    typedef logic [27:0] line_addr_t;

endpackage

// File: rtl/ifq_fetch_ctrl_if.sv
// Instruction-memory line bus between the fetch sequencer (master) and memory (slave).
interface ifq_fetch_ctrl_if;

    logic                       mem_req;
    logic [31:0]                mem_addr;
    logic                       mem_gnt;
    logic                       mem_rvalid;
    logic [ifq_pkg::LINE_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/ifq_addr_fifo.sv
// In-order FIFO of line tags for requests still expected to produce a fill.
module ifq_addr_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  line_addr_t i_push_tag,
    input  logic       i_pop,
    output line_addr_t o_head_tag
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    line_addr_t     r_mem [DEPTH];
    logic [PW-1:0]  r_wr;
    logic [PW-1:0]  r_rd;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_push_tag;
                r_wr        <= ptrInc(r_wr);
            end
            if (i_pop) begin
                r_rd <= ptrInc(r_rd);
            end
        end
    end

    assign o_head_tag = r_mem[r_rd];

endmodule

// File: rtl/ifq_fetch_ctrl.sv
// Line-fetch sequencer: issues line requests under IFQ credit flow control, forwards fills,
// and squashes in-flight lines after a redirect.
module ifq_fetch_ctrl
    import ifq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IFQ_DEPTH = 4,
    parameter int          MAX_OUT   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_halt,
    input  logic              i_redirect_valid,
    input  logic [31:0]       i_redirect_addr,
    input  logic              i_line_consumed,
    ifq_fetch_ctrl_if.master  mem,
    output logic              o_fill_valid,
    output logic [LINE_W-1:0] o_fill_data,
    output logic [31:0]       o_fill_addr,
    output logic              o_err
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(IFQ_DEPTH + 1);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [OW-1:0]      r_outst;
    logic [OW-1:0]      r_kill;
    logic [OW-1:0]      w_outst_next;
    logic [OW-1:0]      w_kill_next;
    logic [CW-1:0]      r_cred;
    logic [CW-1:0]      w_cred_next;
    logic [CW:0]        w_cred_sum;
    logic [31:0]        r_addr;
    logic               r_req_pend;
    logic               w_req;
    logic               w_gnt_fire;
    logic               w_rv_ok;
    logic               w_rv_kill;
    logic               w_rv_fill;
    logic               r_fill_valid;
    logic [LINE_W-1:0]  r_fill_data;
    logic [31:0]        r_fill_addr;
    logic               r_err;
    line_addr_t         w_head_tag;
    logic               w_unused;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A request raised but not yet granted stays up until accepted, even in HALT.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                w_req = r_req_pend |
                        (~i_halt & (r_cred != '0) & (r_outst < OW'(MAX_OUT)));
                if (i_redirect_valid) begin
                    w_state_next = REDIRECT;
                end else if (i_halt) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                w_req = r_req_pend;
                if (i_redirect_valid) begin
                    w_state_next = REDIRECT;
                end else if (!i_halt) begin
                    w_state_next = FETCH;
                end
            end
            REDIRECT: begin
                if (i_redirect_valid) begin
                    w_state_next = REDIRECT;
                end else if (i_halt) begin
                    w_state_next = HALT;
                end else begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_gnt_fire   = w_req & mem.mem_gnt;
    assign w_rv_ok      = mem.mem_rvalid & (r_outst != '0);
    assign w_rv_kill    = w_rv_ok & (r_kill != '0);
    assign w_rv_fill    = w_rv_ok & (r_kill == '0) & ~i_redirect_valid;
    assign w_outst_next = r_outst + OW'(w_gnt_fire) - OW'(w_rv_ok);

    // On redirect everything still in flight (including this cycle's grant) becomes a kill.
    always_comb begin
        w_cred_sum  = {1'b0, r_cred} - (CW+1)'(w_gnt_fire) + (CW+1)'(w_rv_kill)
                      + (CW+1)'(i_line_consumed);
        w_kill_next = r_kill - OW'(w_rv_kill);
        w_cred_next = (w_cred_sum > (CW+1)'(IFQ_DEPTH)) ? CW'(IFQ_DEPTH) : w_cred_sum[CW-1:0];
        if (i_redirect_valid) begin
            w_kill_next = w_outst_next;
            w_cred_next = CW'(IFQ_DEPTH) - CW'(w_outst_next);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_outst      <= '0;
            r_kill       <= '0;
            r_cred       <= CW'(IFQ_DEPTH);
            r_addr       <= RESET_PC & ~32'hF;
            r_req_pend   <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_data  <= '0;
            r_fill_addr  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_outst      <= w_outst_next;
            r_kill       <= w_kill_next;
            r_cred       <= w_cred_next;
            r_req_pend   <= w_req & ~mem.mem_gnt & ~i_redirect_valid;
            r_fill_valid <= w_rv_fill;
            r_err        <= r_err | (mem.mem_rvalid & (r_outst == '0));
            if (i_redirect_valid) begin
                r_addr <= {i_redirect_addr[31:4], 4'h0};
            end else if (w_gnt_fire) begin
                r_addr <= r_addr + 32'(LINE_BYTES);
            end
            if (w_rv_fill) begin
                r_fill_data <= mem.mem_rdata;
                r_fill_addr <= {w_head_tag, 4'h0};
            end
        end
    end

    ifq_addr_fifo #(
        .DEPTH (MAX_OUT)
    ) u_addr_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_redirect_valid),
        .i_push     (w_gnt_fire & ~i_redirect_valid),
        .i_push_tag (r_addr[31:4]),
        .i_pop      (w_rv_fill),
        .o_head_tag (w_head_tag)
    );

    assign mem.mem_req  = w_req;
    assign mem.mem_addr = r_addr;
    assign o_fill_valid = r_fill_valid;
    assign o_fill_data  = r_fill_data;
    assign o_fill_addr  = r_fill_addr;
    assign o_err        = r_err;
    assign w_unused     = &{1'b0, i_redirect_addr[3:0]};

endmodule
